// File: rtl/axi4_slice_bus0_if.sv
// AXI4 signal bundle for one bus0 slave port; master drives requests, slave drives responses.
interface axi4_slice_bus0_if;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [2:0]  aw_prot;
  logic [3:0]  aw_id;
  logic [0:0]  aw_user;

  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic [0:0]  w_user;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [0:0]  b_user;

  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [2:0]  ar_prot;
  logic [3:0]  ar_id;
  logic [0:0]  ar_user;

  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;
  logic [0:0]  r_user;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_id, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_resp, b_id, b_user,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_id, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_id, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_resp, b_id, b_user,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_id, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id, r_user,
    input  r_ready
  );
endinterface

// File: rtl/axi4_slice_bus0.sv
// AXI4 register slice between a bus0 interconnect slave port and its device.
// Each channel is either a 2-entry skid buffer or a plain wire-through.
module axi4_slice_bus0_chan #(
  parameter int WIDTH = 1,
  parameter bit SLICE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             snk_valid,
  input  logic             snk_ready,
  output logic [WIDTH-1:0] snk_data
);
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_e;

  if (SLICE) begin : g_slice
    state_e           state_r, state_nxt_s;
    logic [WIDTH-1:0] ent0_r, ent1_r, ent0_nxt_s, ent1_nxt_s;
    logic             push_s, pop_s;

    // Handshakes depend only on registered occupancy; reset forces both low.
    assign src_ready = !rst && (state_r != S_FULL);
    assign snk_valid = !rst && (state_r != S_EMPTY);
    assign snk_data  = ent0_r;
    assign push_s    = src_valid && src_ready;
    assign pop_s     = snk_valid && snk_ready;

    // Occupancy next-state and entry shifting.
    always_comb begin
      state_nxt_s = state_r;
      ent0_nxt_s  = ent0_r;
      ent1_nxt_s  = ent1_r;
      case (state_r)
        S_EMPTY: begin
          if (push_s) begin
            ent0_nxt_s  = src_data;
            state_nxt_s = S_ONE;
          end else begin
            state_nxt_s = S_EMPTY;
          end
        end
        S_ONE: begin
          if (push_s && pop_s) begin
            ent0_nxt_s  = src_data;
            state_nxt_s = S_ONE;
          end else if (push_s) begin
            ent1_nxt_s  = src_data;
            state_nxt_s = S_FULL;
          end else if (pop_s) begin
            state_nxt_s = S_EMPTY;
          end else begin
            state_nxt_s = S_ONE;
          end
        end
        S_FULL: begin
          if (pop_s) begin
            ent0_nxt_s  = ent1_r;
            state_nxt_s = S_ONE;
          end else begin
            state_nxt_s = S_FULL;
          end
        end
        default: state_nxt_s = S_EMPTY;
      endcase
    end

    // State and entry registers; reset drops any buffered beats.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= S_EMPTY;
        ent0_r  <= {WIDTH{1'b0}};
        ent1_r  <= {WIDTH{1'b0}};
      end else begin
        state_r <= state_nxt_s;
        ent0_r  <= ent0_nxt_s;
        ent1_r  <= ent1_nxt_s;
      end
    end
  end else begin : g_bypass
    assign src_ready = snk_ready;
    assign snk_valid = src_valid;
    assign snk_data  = src_data;
  end
endmodule

module axi4_slice_bus0 #(
  parameter bit AR_SLICE = 1'b1,
  parameter bit AW_SLICE = 1'b1,
  parameter bit W_SLICE  = 1'b1,
  parameter bit R_SLICE  = 1'b1,
  parameter bit B_SLICE  = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  axi4_slice_bus0_if.slave   xslv,
  axi4_slice_bus0_if.master  xdev
);
  localparam int AX_W = 32 + 8 + 3 + 2 + 3 + 4 + 1;
  localparam int W_W  = 32 + 4 + 1 + 1;
  localparam int B_W  = 2 + 4 + 1;
  localparam int R_W  = 32 + 2 + 1 + 4 + 1;

  logic [AX_W-1:0] ar_src_s, ar_snk_s, aw_src_s, aw_snk_s;
  logic [W_W-1:0]  w_src_s, w_snk_s;
  logic [B_W-1:0]  b_src_s, b_snk_s;
  logic [R_W-1:0]  r_src_s, r_snk_s;

  assign ar_src_s = {xslv.ar_addr, xslv.ar_len, xslv.ar_size, xslv.ar_burst,
                     xslv.ar_prot, xslv.ar_id, xslv.ar_user};
  assign {xdev.ar_addr, xdev.ar_len, xdev.ar_size, xdev.ar_burst,
          xdev.ar_prot, xdev.ar_id, xdev.ar_user} = ar_snk_s;
  assign aw_src_s = {xslv.aw_addr, xslv.aw_len, xslv.aw_size, xslv.aw_burst,
                     xslv.aw_prot, xslv.aw_id, xslv.aw_user};
  assign {xdev.aw_addr, xdev.aw_len, xdev.aw_size, xdev.aw_burst,
          xdev.aw_prot, xdev.aw_id, xdev.aw_user} = aw_snk_s;
  assign w_src_s = {xslv.w_data, xslv.w_strb, xslv.w_last, xslv.w_user};
  assign {xdev.w_data, xdev.w_strb, xdev.w_last, xdev.w_user} = w_snk_s;
  // Response channels flow from the device back towards the interconnect.
  assign b_src_s = {xdev.b_resp, xdev.b_id, xdev.b_user};
  assign {xslv.b_resp, xslv.b_id, xslv.b_user} = b_snk_s;
  assign r_src_s = {xdev.r_data, xdev.r_resp, xdev.r_last, xdev.r_id, xdev.r_user};
  assign {xslv.r_data, xslv.r_resp, xslv.r_last, xslv.r_id, xslv.r_user} = r_snk_s;

  axi4_slice_bus0_chan #(.WIDTH(AX_W), .SLICE(AR_SLICE)) u_ar (
    .clk(i_clk), .rst(i_rst),
    .src_valid(xslv.ar_valid), .src_ready(xslv.ar_ready), .src_data(ar_src_s),
    .snk_valid(xdev.ar_valid), .snk_ready(xdev.ar_ready), .snk_data(ar_snk_s));

  axi4_slice_bus0_chan #(.WIDTH(AX_W), .SLICE(AW_SLICE)) u_aw (
    .clk(i_clk), .rst(i_rst),
    .src_valid(xslv.aw_valid), .src_ready(xslv.aw_ready), .src_data(aw_src_s),
    .snk_valid(xdev.aw_valid), .snk_ready(xdev.aw_ready), .snk_data(aw_snk_s));

  axi4_slice_bus0_chan #(.WIDTH(W_W), .SLICE(W_SLICE)) u_w (
    .clk(i_clk), .rst(i_rst),
    .src_valid(xslv.w_valid), .src_ready(xslv.w_ready), .src_data(w_src_s),
    .snk_valid(xdev.w_valid), .snk_ready(xdev.w_ready), .snk_data(w_snk_s));

  axi4_slice_bus0_chan #(.WIDTH(B_W), .SLICE(B_SLICE)) u_b (
    .clk(i_clk), .rst(i_rst),
    .src_valid(xdev.b_valid), .src_ready(xdev.b_ready), .src_data(b_src_s),
    .snk_valid(xslv.b_valid), .snk_ready(xslv.b_ready), .snk_data(b_snk_s));

  axi4_slice_bus0_chan #(.WIDTH(R_W), .SLICE(R_SLICE)) u_r (
    .clk(i_clk), .rst(i_rst),
    .src_valid(xdev.r_valid), .src_ready(xdev.r_ready), .src_data(r_src_s),
    .snk_valid(xslv.r_valid), .snk_ready(xslv.r_ready), .snk_data(r_snk_s));
endmodule

// File: tb/tb_axi4_slice_bus0.sv
// Directed bench for axi4_slice_bus0: reset, streaming, stall, ready toggling, bypass, mid-burst reset.
module tb_axi4_slice_bus0;
  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  axi4_slice_bus0_if up0 ();
  axi4_slice_bus0_if dn0 ();
  axi4_slice_bus0_if up1 ();
  axi4_slice_bus0_if dn1 ();

  axi4_slice_bus0 dut (.i_clk(clk), .i_rst(rst), .xslv(up0), .xdev(dn0));
  axi4_slice_bus0 #(.AR_SLICE(1'b0)) dut_byp (.i_clk(clk), .i_rst(rst), .xslv(up1), .xdev(dn1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    up0.aw_valid = 1'b0; up0.aw_addr = 32'h0; up0.aw_len = 8'h0; up0.aw_size = 3'h0;
    up0.aw_burst = 2'h0; up0.aw_prot = 3'h0; up0.aw_id = 4'h0; up0.aw_user = 1'b0;
    up0.w_valid = 1'b0; up0.w_data = 32'h0; up0.w_strb = 4'h0; up0.w_last = 1'b0; up0.w_user = 1'b0;
    up0.ar_valid = 1'b0; up0.ar_addr = 32'h0; up0.ar_len = 8'h0; up0.ar_size = 3'h0;
    up0.ar_burst = 2'h0; up0.ar_prot = 3'h0; up0.ar_id = 4'h0; up0.ar_user = 1'b0;
    up0.b_ready = 1'b0; up0.r_ready = 1'b0;
    dn0.aw_ready = 1'b0; dn0.w_ready = 1'b0; dn0.ar_ready = 1'b0;
    dn0.b_valid = 1'b0; dn0.b_resp = 2'h0; dn0.b_id = 4'h0; dn0.b_user = 1'b0;
    dn0.r_valid = 1'b0; dn0.r_data = 32'h0; dn0.r_resp = 2'h0; dn0.r_last = 1'b0;
    dn0.r_id = 4'h0; dn0.r_user = 1'b0;
    up1.aw_valid = 1'b0; up1.aw_addr = 32'h0; up1.aw_len = 8'h0; up1.aw_size = 3'h0;
    up1.aw_burst = 2'h0; up1.aw_prot = 3'h0; up1.aw_id = 4'h0; up1.aw_user = 1'b0;
    up1.w_valid = 1'b0; up1.w_data = 32'h0; up1.w_strb = 4'h0; up1.w_last = 1'b0; up1.w_user = 1'b0;
    up1.ar_valid = 1'b0; up1.ar_addr = 32'h0; up1.ar_len = 8'h0; up1.ar_size = 3'h0;
    up1.ar_burst = 2'h0; up1.ar_prot = 3'h0; up1.ar_id = 4'h0; up1.ar_user = 1'b0;
    up1.b_ready = 1'b0; up1.r_ready = 1'b0;
    dn1.aw_ready = 1'b0; dn1.w_ready = 1'b0; dn1.ar_ready = 1'b0;
    dn1.b_valid = 1'b0; dn1.b_resp = 2'h0; dn1.b_id = 4'h0; dn1.b_user = 1'b0;
    dn1.r_valid = 1'b0; dn1.r_data = 32'h0; dn1.r_resp = 2'h0; dn1.r_last = 1'b0;
    dn1.r_id = 4'h0; dn1.r_user = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    up0.ar_valid = 1'b1;
    up0.ar_addr = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if (dn0.ar_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ar_valid cyc=%0d got=%b exp=0", i, dn0.ar_valid); end
      tests_run++;
      if (up0.ar_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ar_ready cyc=%0d got=%b exp=0", i, up0.ar_ready); end
      tests_run++;
      if (dn0.r_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_r_ready cyc=%0d got=%b exp=0", i, dn0.r_ready); end
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (up0.ar_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ar_ready got=%b exp=1", up0.ar_ready); end
    tests_run++;
    if (dn0.ar_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_ar_valid got=%b exp=0", dn0.ar_valid); end
    tests_run++;
    if ({up0.aw_ready, up0.w_ready, dn0.b_ready, dn0.r_ready} !== 4'b1111) begin
      tests_failed++; $display("FAIL post_reset_readies got=%b exp=1111", {up0.aw_ready, up0.w_ready, dn0.b_ready, dn0.r_ready});
    end
    tests_run++;
    if ({dn0.aw_valid, dn0.w_valid, up0.b_valid, up0.r_valid} !== 4'b0000) begin
      tests_failed++; $display("FAIL post_reset_valids got=%b exp=0000", {dn0.aw_valid, dn0.w_valid, up0.b_valid, up0.r_valid});
    end
    up0.ar_valid = 1'b0;
  endtask

  task automatic test_stream_read();
    up0.r_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      dn0.r_valid = (k < 8);
      dn0.r_data  = 32'h10 + 32'(k);
      dn0.r_last  = (k == 7);
      dn0.r_id    = 4'h2;
      #1;
      if (k < 8) begin
        tests_run++;
        if (dn0.r_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_src_ready k=%0d got=%b exp=1", k, dn0.r_ready); end
      end
      if (k == 0 || k == 9) begin
        tests_run++;
        if (up0.r_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_valid_idle k=%0d got=%b exp=0", k, up0.r_valid); end
      end else begin
        tests_run++;
        if (up0.r_valid !== 1'b1 || up0.r_data !== 32'h10 + 32'(k - 1) || up0.r_last !== (k == 8) || up0.r_id !== 4'h2) begin
          tests_failed++;
          $display("FAIL stream_beat k=%0d got v=%b d=%h l=%b id=%h exp v=1 d=%h l=%b id=2",
                   k, up0.r_valid, up0.r_data, up0.r_last, up0.r_id, 32'h10 + 32'(k - 1), (k == 8));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      tick();
      up0.aw_valid = 1'b1; up0.aw_addr = 32'h8000_1000;
      up0.aw_id    = (c == 0) ? 4'h1 : (c == 1) ? 4'h2 : 4'h3;
      up0.w_valid  = 1'b1; up0.w_data = 32'h0000_00A5;
      up0.w_strb   = (c == 0) ? 4'h1 : (c == 1) ? 4'h3 : 4'hF;
      dn0.aw_ready = 1'b0; dn0.w_ready = 1'b0;
      #1;
      tests_run++;
      if (up0.aw_ready !== (c < 2) || up0.w_ready !== (c < 2)) begin
        tests_failed++; $display("FAIL bp_src_ready c=%0d got aw=%b w=%b exp=%b", c, up0.aw_ready, up0.w_ready, (c < 2));
      end
      tests_run++;
      if (dn0.aw_valid !== (c >= 1) || dn0.w_valid !== (c >= 1)) begin
        tests_failed++; $display("FAIL bp_snk_valid c=%0d got aw=%b w=%b exp=%b", c, dn0.aw_valid, dn0.w_valid, (c >= 1));
      end
      if (c >= 1) begin
        tests_run++;
        if (dn0.aw_addr !== 32'h8000_1000 || dn0.aw_id !== 4'h1 || dn0.w_data !== 32'h0000_00A5 || dn0.w_strb !== 4'h1) begin
          tests_failed++; $display("FAIL bp_hold c=%0d got addr=%h id=%h d=%h s=%h exp 80001000/1/a5/1", c, dn0.aw_addr, dn0.aw_id, dn0.w_data, dn0.w_strb);
        end
      end
    end
    tick();
    up0.aw_valid = 1'b0; up0.w_valid = 1'b0;
    dn0.aw_ready = 1'b1; dn0.w_ready = 1'b1;
    #1;
    tests_run++;
    if (dn0.aw_valid !== 1'b1 || dn0.aw_id !== 4'h1 || dn0.w_strb !== 4'h1 || up0.aw_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drain0 got v=%b id=%h s=%h rdy=%b exp 1/1/1/0", dn0.aw_valid, dn0.aw_id, dn0.w_strb, up0.aw_ready);
    end
    tick();
    #1;
    tests_run++;
    if (dn0.aw_valid !== 1'b1 || dn0.aw_id !== 4'h2 || dn0.aw_addr !== 32'h8000_1000 ||
        dn0.w_strb !== 4'h3 || dn0.w_data !== 32'h0000_00A5 || up0.aw_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_drain1 got v=%b id=%h s=%h rdy=%b exp 1/2/3/1", dn0.aw_valid, dn0.aw_id, dn0.w_strb, up0.aw_ready);
    end
    tick();
    #1;
    tests_run++;
    if (dn0.aw_valid !== 1'b0 || dn0.w_valid !== 1'b0 || up0.aw_ready !== 1'b1 || up0.w_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_empty got av=%b wv=%b ar=%b wr=%b exp 0/0/1/1", dn0.aw_valid, dn0.w_valid, up0.aw_ready, up0.w_ready);
    end
    dn0.aw_ready = 1'b0; dn0.w_ready = 1'b0;
  endtask

  task automatic test_b_toggle();
    int         src = 0;
    int         n = 0;
    logic [3:0] got [4];
    for (int i = 0; i < 4; i++) got[i] = 4'h0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      dn0.b_valid = (src < 4);
      dn0.b_id    = 4'(3 + src);
      dn0.b_resp  = 2'h0;
      up0.b_ready = (c % 2 == 0);
      #1;
      if (dn0.b_valid && dn0.b_ready) src++;
      if (up0.b_valid && up0.b_ready) begin
        got[n] = up0.b_id;
        n++;
      end
    end
    dn0.b_valid = 1'b0;
    tests_run++;
    if (n !== 4) begin tests_failed++; $display("FAIL btoggle_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got[i] !== 4'(3 + i)) begin tests_failed++; $display("FAIL btoggle_id idx=%0d got=%0d exp=%0d", i, got[i], 3 + i); end
    end
    tick();
    up0.b_ready = 1'b1;
    #1;
    tests_run++;
    if (up0.b_valid !== 1'b0) begin tests_failed++; $display("FAIL btoggle_nodup got=%b exp=0", up0.b_valid); end
  endtask

  task automatic test_bypass();
    tick();
    up1.ar_valid = 1'b1;
    up1.ar_addr  = 32'h0001_0000;
    dn1.ar_ready = 1'b0;
    #1;
    tests_run++;
    if (dn1.ar_valid !== 1'b1 || dn1.ar_addr !== 32'h0001_0000) begin
      tests_failed++; $display("FAIL bypass_fwd got v=%b a=%h exp 1/00010000", dn1.ar_valid, dn1.ar_addr);
    end
    tests_run++;
    if (up1.ar_ready !== 1'b0) begin tests_failed++; $display("FAIL bypass_ready_lo got=%b exp=0", up1.ar_ready); end
    dn1.ar_ready = 1'b1;
    #1;
    tests_run++;
    if (up1.ar_ready !== 1'b1) begin tests_failed++; $display("FAIL bypass_ready_hi got=%b exp=1", up1.ar_ready); end
    up1.ar_valid = 1'b0;
    #1;
    tests_run++;
    if (dn1.ar_valid !== 1'b0) begin tests_failed++; $display("FAIL bypass_valid_drop got=%b exp=0", dn1.ar_valid); end
  endtask

  task automatic test_mid_reset();
    up0.r_ready = 1'b0;
    tick();
    dn0.r_valid = 1'b1; dn0.r_data = 32'h20; dn0.r_last = 1'b0; dn0.r_id = 4'h1;
    tick();
    dn0.r_data = 32'h21;
    #1;
    tests_run++;
    if (up0.r_valid !== 1'b1 || up0.r_data !== 32'h20) begin
      tests_failed++; $display("FAIL midrst_first got v=%b d=%h exp 1/20", up0.r_valid, up0.r_data);
    end
    tick();
    dn0.r_valid = 1'b0;
    #1;
    tests_run++;
    if (dn0.r_ready !== 1'b0 || up0.r_valid !== 1'b1 || up0.r_data !== 32'h20) begin
      tests_failed++; $display("FAIL midrst_full got rdy=%b v=%b d=%h exp 0/1/20", dn0.r_ready, up0.r_valid, up0.r_data);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (up0.r_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_reset got=%b exp=0", up0.r_valid); end
    tick();
    rst = 1'b0;
    up0.r_ready = 1'b1;
    #1;
    tests_run++;
    if (up0.r_valid !== 1'b0 || dn0.r_ready !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_after got v=%b rdy=%b exp 0/1", up0.r_valid, dn0.r_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if (up0.r_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, up0.r_valid); end
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_stream_read();
    test_backpressure();
    test_b_toggle();
    test_bypass();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
